// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int          PC_STEP  = 4;

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instruction} pairs toward ID.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        push,
    input  logic [WIDTH-1:0]            din,
    input  logic                        pop,
    output logic [WIDTH-1:0]            dout,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// IF stage sequencer: owns the PC, issues in-order IMEM requests under a credit
// limit, buffers responses toward ID and discards stale responses after redirects.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              IQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            branch_sel,
    input  logic [XLEN-1:0] branch_inp,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_inst,
    output logic [XLEN-1:0] pc_present,
    output fetch_state_e    fsm_state
);

    localparam int              CW      = cnt_width(IQ_DEPTH);
    localparam int              QW      = XLEN + 32;
    localparam logic [CW:0]     CREDITS = (CW+1)'(IQ_DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   out_cnt_next;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_cnt_next;
    logic [XLEN-1:0] target;
    logic            credit_ok;
    logic            issue;
    logic            dropping;
    logic            q_push;
    logic            q_pop;
    logic [QW-1:0]   q_dout;
    logic [CW-1:0]   q_count;
    logic            q_full;
    logic            q_empty;
    logic            unused_bits;

    assign target      = {branch_inp[XLEN-1:2], 2'b00};
    assign unused_bits = ^branch_inp[1:0];

    // Credits cover both in-flight requests and buffered words, so a response always has a slot.
    assign credit_ok = ({1'b0, out_cnt} + {1'b0, q_count}) < CREDITS;
    assign imem_req  = (state == RUN) & ~branch_sel & credit_ok;
    assign issue     = imem_req & imem_gnt;

    assign out_cnt_next = out_cnt + CW'(issue) - CW'(imem_rvalid);
    assign dropping     = imem_rvalid & (drop_cnt != '0);
    assign q_push       = imem_rvalid & ~dropping & ~branch_sel;

    assign id_valid = ~q_empty & ~branch_sel;
    assign q_pop    = id_valid & id_ready;
    assign id_pc    = id_valid ? q_dout[QW-1:32] : '0;
    assign id_inst  = id_valid ? q_dout[31:0] : NOP_INST;

    assign imem_addr  = pc;
    assign pc_present = pc;
    assign fsm_state  = state;

    always_comb begin
        drop_cnt_next = drop_cnt;
        if (branch_sel) begin
            drop_cnt_next = out_cnt_next;
        end else if (dropping) begin
            drop_cnt_next = drop_cnt - CW'(1);
        end
    end

    // A redirect with nothing left in flight needs no flush window, so fetching
    // at the target resumes on the very next cycle.
    always_comb begin
        state_next = state;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (branch_sel) begin
                    state_next = (drop_cnt_next == '0) ? RUN : FLUSH;
                end
            end
            FLUSH: begin
                if (drop_cnt_next == '0) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            resp_pc  <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            out_cnt  <= out_cnt_next;
            drop_cnt <= drop_cnt_next;
            if (branch_sel) begin
                pc <= target;
            end else if (issue) begin
                pc <= pc + STEP;
            end
            if (branch_sel) begin
                resp_pc <= target;
            end else if (q_push) begin
                resp_pc <= resp_pc + STEP;
            end
        end
    end

    fetch_queue #(
        .WIDTH(QW),
        .DEPTH(IQ_DEPTH)
    ) u_queue (
        .clk  (clk),
        .reset(reset),
        .clear(branch_sel),
        .push (q_push),
        .din  ({resp_pc, imem_rdata}),
        .pop  (q_pop),
        .dout (q_dout),
        .count(q_count),
        .full (q_full),
        .empty(q_empty)
    );

    // IMEM protocol: no response without an outstanding request, none into a full queue.
    assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && out_cnt == '0));
    assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && q_full && !branch_sel && drop_cnt == '0));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a queue-based model of the fetch stream.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          IQ_DEPTH = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         branch_sel = 1'b0;
    logic [31:0]  branch_inp = '0;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_gnt = 1'b0;
    logic         imem_rvalid = 1'b0;
    logic [31:0]  imem_rdata = '0;
    logic         id_valid;
    logic         id_ready = 1'b0;
    logic [31:0]  id_pc;
    logic [31:0]  id_inst;
    logic [31:0]  pc_present;
    fetch_state_e fsm_state;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .XLEN(XLEN),
        .RESET_PC(RESET_PC),
        .IQ_DEPTH(IQ_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .branch_sel(branch_sel),
        .branch_inp(branch_inp),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_pc(id_pc),
        .id_inst(id_inst),
        .pc_present(pc_present),
        .fsm_state(fsm_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: fetch stream, in-flight requests with stale marks, expected ID queue.
    logic [31:0] model_pc;
    bit          boot;
    logic [31:0] infl_addr[$];
    bit          infl_stale[$];
    logic [63:0] exp_q[$];
    logic [31:0] imem_q[$];

    int          gnt_pct, rv_pct, rdy_pct, br_pct;
    bit          force_br = 1'b0;
    logic [31:0] br_target = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a * 32'd3 + 32'h1357_0001;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (infl_stale[i]) if (infl_stale[i]) n++;
        return n;
    endfunction

    task automatic set_knobs(input int g, input int rv, input int rdy, input int br);
        gnt_pct = g;
        rv_pct  = rv;
        rdy_pct = rdy;
        br_pct  = br;
    endtask

    task automatic drive();
        imem_gnt = int'($urandom_range(0, 99)) < gnt_pct;
        if (imem_q.size() > 0 && int'($urandom_range(0, 99)) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = inst_of(imem_q[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        id_ready = int'($urandom_range(0, 99)) < rdy_pct;
        if (force_br) begin
            branch_sel = 1'b1;
            branch_inp = br_target;
        end else if (int'($urandom_range(0, 99)) < br_pct) begin
            branch_sel = 1'b1;
            branch_inp = $urandom;
        end else begin
            branch_sel = 1'b0;
            branch_inp = $urandom;
        end
    endtask

    task automatic check_and_update();
        bit           exp_req;
        bit           exp_valid;
        fetch_state_e exp_state;
        logic [31:0]  a;
        bit           st;
        exp_req   = !boot && stale_cnt() == 0 && !branch_sel &&
                    (infl_addr.size() + exp_q.size() < IQ_DEPTH);
        exp_valid = exp_q.size() > 0 && !branch_sel;
        exp_state = boot ? BOOT : (stale_cnt() > 0 ? FLUSH : RUN);
        check("imem_req", imem_req, exp_req);
        check("pc_present", pc_present, model_pc);
        check("imem_addr", imem_addr, model_pc);
        check("id_valid", id_valid, exp_valid);
        check("state", fsm_state, exp_state);
        if (exp_valid) begin
            check("id_pc", id_pc, exp_q[0][63:32]);
            check("id_inst", id_inst, exp_q[0][31:0]);
        end else begin
            check("id_inst_nop", id_inst, NOP_INST);
        end
        // memory side follows what the DUT actually did
        if (imem_req && imem_gnt) imem_q.push_back(imem_addr);
        if (imem_rvalid && imem_q.size() > 0) void'(imem_q.pop_front());
        // model side
        if (exp_valid && id_ready) void'(exp_q.pop_front());
        if (imem_rvalid && infl_addr.size() > 0) begin
            a  = infl_addr.pop_front();
            st = infl_stale.pop_front();
            if (!st && !branch_sel) exp_q.push_back({a, inst_of(a)});
        end
        if (exp_req && imem_gnt) begin
            infl_addr.push_back(model_pc);
            infl_stale.push_back(1'b0);
            model_pc = model_pc + 32'd4;
        end
        if (branch_sel) begin
            foreach (infl_stale[i]) infl_stale[i] = 1'b1;
            exp_q.delete();
            model_pc = {branch_inp[31:2], 2'b00};
        end
        boot = 1'b0;
    endtask

    // Entered and left just after a rising edge.
    task automatic cycle();
        drive();
        @(negedge clk);
        check_and_update();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, imem_req, 1'b0);
        check({tag, "_valid"}, id_valid, 1'b0);
        check({tag, "_id_pc"}, id_pc, 32'h0);
        check({tag, "_inst"}, id_inst, NOP_INST);
        check({tag, "_pc"}, pc_present, RESET_PC);
        check({tag, "_state"}, fsm_state, BOOT);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        branch_sel  = 1'b0;
        branch_inp  = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        id_ready    = 1'b0;
        force_br    = 1'b0;
        #2;
        check_reset_outputs("rst_async");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        reset = 1'b0;
        infl_addr.delete();
        infl_stale.delete();
        exp_q.delete();
        imem_q.delete();
        model_pc = RESET_PC;
        boot     = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        force_br  = 1'b1;
        br_target = tgt;
        cycle();
        force_br  = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // steady stream
        set_knobs(100, 100, 100, 0);
        repeat (20) cycle();

        // ID stall: credits run out, requests stop until a pop
        set_knobs(100, 100, 0, 0);
        repeat (6) cycle();
        set_knobs(100, 100, 100, 0);
        repeat (6) cycle();

        // redirect with two outstanding requests
        set_knobs(100, 0, 100, 0);
        repeat (4) cycle();
        redirect(32'd40);
        set_knobs(100, 100, 100, 0);
        repeat (12) cycle();

        // unaligned target, redirect coinciding with rvalid and gnt
        repeat (5) cycle();
        redirect(32'h43);
        repeat (12) cycle();

        // grant withheld
        set_knobs(0, 100, 100, 0);
        repeat (5) cycle();
        set_knobs(100, 100, 100, 0);
        repeat (8) cycle();

        // address wrap
        redirect(32'hFFFF_FFFC);
        repeat (10) cycle();

        // random traffic
        for (int p = 0; p < 6; p++) begin
            set_knobs(int'($urandom_range(20, 100)), int'($urandom_range(20, 100)),
                      int'($urandom_range(20, 100)), int'($urandom_range(0, 8)));
            repeat (400) cycle();
        end

        // reset while flushing two stale responses
        set_knobs(100, 0, 100, 0);
        repeat (4) cycle();
        redirect(32'h100);
        cycle();
        do_reset();
        set_knobs(100, 100, 100, 0);
        repeat (10) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
